// File: rtl/stream_mux_pkg.sv
// Constants shared between the round-robin merger and the downstream 2x1 mux consumers.
package stream_mux_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_grant_2.sv
// Two-requester round-robin arbiter; a tie goes to the requester that did not win last.
module rr_grant_2
   import stream_mux_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic r_last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (r_last_grant == SEL_B) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Priority rotates only when a granted word is actually transferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= SEL_B;
      end else if (advance) begin
         r_last_grant <= gnt[1] ? SEL_B : SEL_A;
      end
   end

endmodule

// File: rtl/rr_stream_mux_2x1.sv
// Fair 2:1 stream merger with a single registered output slot and one-cycle latency.
module rr_stream_mux_2x1
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   input  logic             out_ready
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_sel;

   logic [1:0]       w_gnt;
   logic             w_can_accept;
   logic             w_xfer;
   logic             w_sel;
   logic [WIDTH-1:0] w_data;

   assign w_can_accept = !r_out_valid || out_ready;
   // Masking with rst keeps both readies low while reset is held.
   assign w_xfer       = w_can_accept && (w_gnt != 2'b00) && !rst;

   rr_grant_2 u_grant (
      .clk     (clk),
      .rst     (rst),
      .req     ({b_valid, a_valid}),
      .advance (w_xfer),
      .gnt     (w_gnt)
   );

   assign w_sel  = w_gnt[1] ? SEL_B : SEL_A;
   assign w_data = (w_sel == SEL_B) ? b_data : a_data;

   always_comb begin
      a_ready = w_can_accept && w_gnt[0] && !rst;
      b_ready = w_can_accept && w_gnt[1] && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= SEL_A;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_sel   <= w_sel;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux_2x1.sv
// Vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_rr_stream_mux_2x1;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         a_valid, b_valid, a_ready, b_ready;
   logic [W-1:0] a_data, b_data, out_data;
   logic         out_valid, out_sel, out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         r;
      logic         av;
      logic [W-1:0] ad;
      logic         bv;
      logic [W-1:0] bd;
      logic         ordy;
      logic         exp_ar;
      logic         exp_br;
      logic         exp_ov;
      logic [W-1:0] exp_od;
      logic         exp_os;
   } vec_t;

   vec_t vecs[10];

   rr_stream_mux_2x1 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, check readies before the edge and the slot after it.
   task automatic run_cycle(input string tag, input logic r, input logic av, input logic [W-1:0] ad,
                            input logic bv, input logic [W-1:0] bd, input logic ordy,
                            input logic ear, input logic ebr, input logic eov,
                            input logic [W-1:0] eod, input logic eos);
      rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
      #1;
      chk({tag, ".a_ready"}, 32'(a_ready), 32'(ear));
      chk({tag, ".b_ready"}, 32'(b_ready), 32'(ebr));
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
      chk({tag, ".out_data"}, 32'(out_data), 32'(eod));
      chk({tag, ".out_sel"}, 32'(out_sel), 32'(eos));
   endtask

   // Behavioural reference: slot contents plus the source that last won (0 = A, 1 = B).
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_sel;
   int           m_last;

   function automatic int winner(input logic av, input logic bv, input int last);
      if (av && bv) return (last == 0) ? 1 : 0;
      if (av) return 0;
      if (bv) return 1;
      return -1;
   endfunction

   initial begin
      logic [W-1:0] exp_od;
      logic         pa_v, pb_v;
      logic [W-1:0] pa_d, pb_d;
      logic         ordy, ear, ebr;
      int           w;

      vecs[0] = '{1, 1, 8'h11, 1, 8'h22, 1, 0, 0, 0, 8'h00, 0};
      vecs[1] = '{1, 1, 8'h11, 1, 8'h22, 1, 0, 0, 0, 8'h00, 0};
      vecs[2] = '{0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0};
      vecs[3] = '{0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 1, 8'h22, 1};
      vecs[4] = '{0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0};
      vecs[5] = '{0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 1, 8'h22, 1};
      vecs[6] = '{0, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 8'h22, 1};
      vecs[7] = '{0, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 8'h22, 1};
      vecs[8] = '{0, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 8'h22, 1};
      vecs[9] = '{0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0};

      for (int i = 0; i < 10; i++) begin
         run_cycle($sformatf("vec%0d", i), vecs[i].r, vecs[i].av, vecs[i].ad, vecs[i].bv,
                   vecs[i].bd, vecs[i].ordy, vecs[i].exp_ar, vecs[i].exp_br, vecs[i].exp_ov,
                   vecs[i].exp_od, vecs[i].exp_os);
      end

      // Only B requests: back-to-back words, then A must win the following tie.
      for (int i = 0; i < 4; i++) begin
         run_cycle($sformatf("solo_b%0d", i), 0, 0, 8'h11, 1, W'(8'h05 + i), 1,
                   0, 1, 1, W'(8'h05 + i), 1);
      end
      run_cycle("tie_after_b", 0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0);

      // Drain with nothing to refill: valid drops, data holds.
      run_cycle("drain0", 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h11, 0);
      run_cycle("drain1", 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h11, 0);

      // Reset while FULL and stalled; A last won so only reset makes A win the next tie.
      run_cycle("fill_a", 0, 1, 8'h44, 0, 8'h00, 1, 1, 0, 1, 8'h44, 0);
      run_cycle("mid_rst", 1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 8'h00, 0);
      run_cycle("post_rst", 0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0);

      // Randomized run from a clean reset.
      run_cycle("rnd_rst", 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
      m_valid = 0; m_data = '0; m_sel = 0; m_last = 1;
      pa_v = 0; pb_v = 0; pa_d = '0; pb_d = '0;
      for (int c = 0; c < 400; c++) begin
         if (!pa_v && ($urandom_range(0, 3) != 0)) begin
            pa_v = 1; pa_d = W'($urandom);
         end
         if (!pb_v && ($urandom_range(0, 3) != 0)) begin
            pb_v = 1; pb_d = W'($urandom);
         end
         ordy = ($urandom_range(0, 3) != 0);
         w    = winner(pa_v, pb_v, m_last);
         ear  = (!m_valid || ordy) && (w == 0);
         ebr  = (!m_valid || ordy) && (w == 1);
         rst = 0; a_valid = pa_v; a_data = pa_d; b_valid = pb_v; b_data = pb_d;
         out_ready = ordy;
         #1;
         chk("rnd.a_ready", 32'(a_ready), 32'(ear));
         chk("rnd.b_ready", 32'(b_ready), 32'(ebr));
         if (ear) begin
            m_valid = 1; m_data = pa_d; m_sel = 0; m_last = 0; pa_v = 0;
         end else if (ebr) begin
            m_valid = 1; m_data = pb_d; m_sel = 1; m_last = 1; pb_v = 0;
         end else if (ordy) begin
            m_valid = 0;
         end
         @(posedge clk);
         @(negedge clk);
         exp_od = m_data;
         chk("rnd.out_valid", 32'(out_valid), 32'(m_valid));
         chk("rnd.out_data", 32'(out_data), 32'(exp_od));
         chk("rnd.out_sel", 32'(out_sel), 32'(m_sel));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
